// File: rtl/subtractor_serial_reg.sv
// Digit-serial two's-complement subtractor: d = a - b - bi, digit bits per clock, LSB first.
// Define SUB_OVERFLOW_EN to add the registered signed-overflow output ov.
module subtractor_serial_reg #(
  parameter int width = 32,
  parameter int digit = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [width-1:0] a,
  input  logic [width-1:0] b,
  input  logic             bi,
  output logic             busy,
  output logic             done,
  output logic [width-1:0] d,
  output logic             bo
`ifdef SUB_OVERFLOW_EN
  ,
  output logic             ov
`endif
);

  localparam int N     = width / digit;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1
  } state_t;

  state_t           r_state;
  logic [width-1:0] r_a;
  logic [width-1:0] r_b;
  logic [width-1:0] r_shadow;
  logic             r_borrow;
  logic [CNT_W-1:0] r_step;

  logic [digit-1:0] w_a_k;
  logic [digit-1:0] w_b_k;
  logic [digit:0]   w_sub;
  logic [width-1:0] w_shadow_next;

  // One digit slice per cycle; the extra top bit of w_sub is the slice borrow-out.
  assign w_a_k = r_a[r_step*digit +: digit];
  assign w_b_k = r_b[r_step*digit +: digit];
  assign w_sub = {1'b0, w_a_k} - {1'b0, w_b_k} - (digit+1)'(r_borrow);

  always_comb begin
    w_shadow_next = r_shadow;
    w_shadow_next[r_step*digit +: digit] = w_sub[digit-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_shadow <= '0;
      r_borrow <= 1'b0;
      r_step   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      d        <= '0;
      bo       <= 1'b0;
`ifdef SUB_OVERFLOW_EN
      ov       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a      <= a;
            r_b      <= b;
            r_borrow <= bi;
            r_step   <= '0;
            busy     <= 1'b1;
            r_state  <= S_RUN;
          end
        end
        S_RUN: begin
          r_shadow <= w_shadow_next;
          r_borrow <= w_sub[digit];
          r_step   <= r_step + CNT_W'(1);
          // Final slice: publish the assembled result, never the partial shadow.
          if (r_step == LAST) begin
            d       <= w_shadow_next;
            bo      <= w_sub[digit];
            done    <= 1'b1;
            busy    <= 1'b0;
            r_state <= S_IDLE;
`ifdef SUB_OVERFLOW_EN
            ov      <= (r_a[width-1] != r_b[width-1]) &&
                       (w_shadow_next[width-1] != r_a[width-1]);
`endif
          end
        end
        default: begin
          busy    <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_subtractor_serial_reg.sv
// Directed bench for subtractor_serial_reg at default parameters (N = 4 digit steps).
module tb_subtractor_serial_reg;

  localparam int W = 32;
  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bi;
  logic         busy;
  logic         done;
  logic [W-1:0] d;
  logic         bo;
`ifdef SUB_OVERFLOW_EN
  logic         ov;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  subtractor_serial_reg #(.width(W), .digit(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .bi    (bi),
    .busy  (busy),
    .done  (done),
    .d     (d),
    .bo    (bo)
`ifdef SUB_OVERFLOW_EN
    ,
    .ov    (ov)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_ov(input string tag, input logic exp_ov);
`ifdef SUB_OVERFLOW_EN
    chk({tag, "_ov"}, 64'(ov), 64'(exp_ov));
`endif
  endtask

  task automatic run_op(input string tag, input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic tbi, input logic [W-1:0] exp_d, input logic exp_bo,
                        input logic exp_ov);
    a = ta; b = tb; bi = tbi; start = 1'b1;
    tick();
    start = 1'b0;
    chk({tag, "_busy0"}, 64'({busy, done}), 64'(2'b10));
    for (int k = 1; k < N; k++) begin
      tick();
      chk({tag, "_run"}, 64'({busy, done}), 64'(2'b10));
    end
    tick();
    chk({tag, "_done"}, 64'({busy, done}), 64'(2'b01));
    chk({tag, "_d"}, 64'(d), 64'(exp_d));
    chk({tag, "_bo"}, 64'(bo), 64'(exp_bo));
    chk_ov(tag, exp_ov);
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; a = '0; b = '0; bi = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_d", 64'(d), 64'(0));
    chk("rst_bo", 64'(bo), 64'(0));
    chk_ov("rst", 1'b0);

    run_op("basic", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    tick();
    chk("basic_pulse", 64'({busy, done}), 64'(2'b00));
    chk("basic_hold", 64'(d), 64'h2);

    run_op("wrap", 32'h0000_0000, 32'h0000_0001, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();
    run_op("xdigit", 32'h0000_0100, 32'h0000_0001, 1'b1, 32'h0000_00FE, 1'b0, 1'b0);
    tick();
    run_op("bionly", 32'h0000_0000, 32'h0000_0000, 1'b1, 32'hFFFF_FFFF, 1'b1, 1'b0);
    tick();

    // Second start while busy must be ignored.
    a = 32'd10; b = 32'd4; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    chk("ign_run2", 64'({busy, done}), 64'(2'b10));
    tick();
    chk("ign_run3", 64'({busy, done}), 64'(2'b10));
    tick();
    chk("ign_done", 64'({busy, done}), 64'(2'b01));
    chk("ign_d", 64'(d), 64'h6);
    chk("ign_bo", 64'(bo), 64'(0));
    // Start presented in the done cycle is accepted.
    run_op("b2b", 32'd7, 32'd2, 1'b0, 32'd5, 1'b0, 1'b0);
    tick();
    chk("b2b_single", 64'(done), 64'(0));

    run_op("ovf", 32'h8000_0000, 32'h0000_0001, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1);
    tick();
    run_op("noovf", 32'h0000_0005, 32'h0000_0003, 1'b0, 32'h0000_0002, 1'b0, 1'b0);
    tick();

    // Abort with reset on the second RUN cycle.
    a = 32'd9; b = 32'd1; bi = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'(0));
    chk("abort_d", 64'(d), 64'(0));
    chk("abort_bo", 64'(bo), 64'(0));
    seen_done = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (done === 1'b1) seen_done = 1'b1;
      tick();
    end
    chk("abort_nodone", 64'(seen_done), 64'(0));

    // Reset wins over start in the same cycle.
    a = 32'd3; b = 32'd1; rst = 1'b1; start = 1'b1;
    tick();
    rst = 1'b0; start = 1'b0;
    chk("prio_busy", 64'(busy), 64'(0));
    tick();
    chk("prio_idle", 64'({busy, done}), 64'(2'b00));

    run_op("after", 32'h1234_5678, 32'h0234_5679, 1'b0, 32'h0FFF_FFFF, 1'b0, 1'b0);
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
